// File: rtl/pll_reset_sequencer.sv
// Ordered reset release after PLL lock: SDRAM controller first, then system
// once the SDRAM power-up wait and init-done handshake have both completed.
module pll_reset_sequencer #(
    parameter int SYNC_STAGES         = 2,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int SDRAM_WAIT_CYCLES   = 10000,
    parameter int INIT_TIMEOUT_CYCLES = 65536,
    parameter int CNT_WIDTH           = 17
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       sdram_init_done,
    output logic       sdram_reset,
    output logic       system_reset,
    output logic [1:0] state,
    output logic [7:0] lock_loss_count,
    output logic       init_timeout
);

    typedef enum logic [1:0] {
        S_HOLD   = 2'd0,
        S_STABLE = 2'd1,
        S_INIT   = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] C_STABLE_LAST = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] C_WAIT_LAST   = CNT_WIDTH'(SDRAM_WAIT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] C_TO_LAST     = CNT_WIDTH'(INIT_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] C_ONE         = CNT_WIDTH'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_sdram_reset;
    logic                   r_system_reset;
    logic [7:0]             r_loss_cnt;
    logic                   r_timeout;

    state_t                 w_state_nxt;
    logic [CNT_WIDTH-1:0]   w_cnt_nxt;
    logic                   w_locked;
    logic                   w_loss;
    logic                   w_timeout;

    assign w_locked = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    // Lock loss outranks both completion and timeout in every locked state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_loss      = 1'b0;
        w_timeout   = 1'b0;
        unique case (r_state)
            S_HOLD: begin
                w_cnt_nxt = '0;
                if (w_locked) begin
                    w_state_nxt = S_STABLE;
                end
            end
            S_STABLE: begin
                if (!w_locked) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = '0;
                    w_loss      = 1'b1;
                end else if (r_cnt == C_STABLE_LAST) begin
                    w_state_nxt = S_INIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end
            S_INIT: begin
                if (!w_locked) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = '0;
                    w_loss      = 1'b1;
                end else if (r_cnt >= C_WAIT_LAST && sdram_init_done) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_TO_LAST) begin
                    w_state_nxt = S_STABLE;
                    w_cnt_nxt   = '0;
                    w_timeout   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end
            S_RUN: begin
                w_cnt_nxt = '0;
                if (!w_locked) begin
                    w_state_nxt = S_HOLD;
                    w_loss      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_HOLD;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Reset outputs are decoded from the next state so they change with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= S_HOLD;
            r_cnt          <= '0;
            r_sdram_reset  <= 1'b1;
            r_system_reset <= 1'b1;
            r_loss_cnt     <= '0;
            r_timeout      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_sdram_reset  <= (w_state_nxt == S_HOLD) || (w_state_nxt == S_STABLE);
            r_system_reset <= (w_state_nxt != S_RUN);
            if (w_loss && r_loss_cnt != 8'hFF) begin
                r_loss_cnt <= r_loss_cnt + 8'd1;
            end
            if (w_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign sdram_reset     = r_sdram_reset;
    assign system_reset    = r_system_reset;
    assign state           = r_state;
    assign lock_loss_count = r_loss_cnt;
    assign init_timeout    = r_timeout;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with shortened phase lengths.
// Observed vector: {sdram_reset, system_reset, state, lock_loss_count, init_timeout}.
module tb_pll_reset_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pll_locked = 1'b0;
    logic       sdram_init_done = 1'b0;
    logic       sdram_reset;
    logic       system_reset;
    logic [1:0] state;
    logic [7:0] lock_loss_count;
    logic       init_timeout;

    logic [12:0] obs;
    logic [12:0] exp_v;
    int          n_cmp = 0;
    int          n_fail = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (8),
        .SDRAM_WAIT_CYCLES  (16),
        .INIT_TIMEOUT_CYCLES(32),
        .CNT_WIDTH          (17)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .pll_locked     (pll_locked),
        .sdram_init_done(sdram_init_done),
        .sdram_reset    (sdram_reset),
        .system_reset   (system_reset),
        .state          (state),
        .lock_loss_count(lock_loss_count),
        .init_timeout   (init_timeout)
    );

    always #5 clock = ~clock;

    assign obs = {sdram_reset, system_reset, state, lock_loss_count, init_timeout};

    // Released resets must only ever coincide with the states that allow them.
    always @(negedge clock) begin
        if (!reset) begin
            n_cmp++;
            if ((!sdram_reset && state < 2'd2) || (!system_reset && state != 2'd3)) begin
                n_fail++;
                $display("FAIL invariant: got %h want resets consistent with state", obs);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pll_locked = 1'b0;
        sdram_init_done = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        wait_cycles(2);
        exp_v = {1'b1, 1'b1, 2'd0, 8'd0, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", obs, exp_v);
        end
        reset = 1'b0;
    endtask

    task automatic test_bringup();
        sdram_init_done = 1'b1;
        pll_locked = 1'b1;
        wait_cycles(2);
        exp_v = {1'b1, 1'b1, 2'd0, 8'd0, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL bringup_sync_latency: got %h want %h", obs, exp_v);
        end
        wait_cycles(1);
        exp_v = {1'b1, 1'b1, 2'd1, 8'd0, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL bringup_stable: got %h want %h", obs, exp_v);
        end
        wait_cycles(7);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL bringup_stable_last: got %h want %h", obs, exp_v);
        end
        wait_cycles(1);
        exp_v = {1'b0, 1'b1, 2'd2, 8'd0, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL bringup_init: got %h want %h", obs, exp_v);
        end
        wait_cycles(15);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL bringup_early_done_ignored: got %h want %h", obs, exp_v);
        end
        wait_cycles(1);
        exp_v = {1'b0, 1'b0, 2'd3, 8'd0, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL bringup_run: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_lock_loss_run();
        pll_locked = 1'b0;
        wait_cycles(2);
        exp_v = {1'b0, 1'b0, 2'd3, 8'd0, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL loss_latency: got %h want %h", obs, exp_v);
        end
        wait_cycles(1);
        exp_v = {1'b1, 1'b1, 2'd0, 8'd1, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL loss_hold: got %h want %h", obs, exp_v);
        end
        wait_cycles(7);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL loss_no_recount: got %h want %h", obs, exp_v);
        end
        pll_locked = 1'b1;
        wait_cycles(3);
        exp_v = {1'b1, 1'b1, 2'd1, 8'd1, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL relock_stable: got %h want %h", obs, exp_v);
        end
        wait_cycles(8);
        exp_v = {1'b0, 1'b1, 2'd2, 8'd1, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL relock_init: got %h want %h", obs, exp_v);
        end
        wait_cycles(16);
        exp_v = {1'b0, 1'b0, 2'd3, 8'd1, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL relock_run: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_late_done();
        do_reset();
        pll_locked = 1'b1;
        wait_cycles(26);
        exp_v = {1'b0, 1'b1, 2'd2, 8'd0, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL late_wait_expired: got %h want %h", obs, exp_v);
        end
        wait_cycles(5);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL late_cnt20: got %h want %h", obs, exp_v);
        end
        sdram_init_done = 1'b1;
        wait_cycles(1);
        exp_v = {1'b0, 1'b0, 2'd3, 8'd0, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL late_run: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_glitch_stable();
        do_reset();
        sdram_init_done = 1'b1;
        pll_locked = 1'b1;
        wait_cycles(8);
        exp_v = {1'b1, 1'b1, 2'd1, 8'd0, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL glitch_cnt5: got %h want %h", obs, exp_v);
        end
        pll_locked = 1'b0;
        wait_cycles(2);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL glitch_pre: got %h want %h", obs, exp_v);
        end
        wait_cycles(1);
        exp_v = {1'b1, 1'b1, 2'd0, 8'd1, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL glitch_priority_hold: got %h want %h", obs, exp_v);
        end
        pll_locked = 1'b1;
        wait_cycles(2);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL glitch_still_hold: got %h want %h", obs, exp_v);
        end
        wait_cycles(1);
        exp_v = {1'b1, 1'b1, 2'd1, 8'd1, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL glitch_restable: got %h want %h", obs, exp_v);
        end
        wait_cycles(7);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL glitch_full_stable: got %h want %h", obs, exp_v);
        end
        wait_cycles(1);
        exp_v = {1'b0, 1'b1, 2'd2, 8'd1, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL glitch_init: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        pll_locked = 1'b1;
        wait_cycles(42);
        exp_v = {1'b0, 1'b1, 2'd2, 8'd0, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL timeout_last_init: got %h want %h", obs, exp_v);
        end
        wait_cycles(1);
        exp_v = {1'b1, 1'b1, 2'd1, 8'd0, 1'b1};
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL timeout_retry: got %h want %h", obs, exp_v);
        end
        wait_cycles(39);
        exp_v = {1'b0, 1'b1, 2'd2, 8'd0, 1'b1};
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL timeout_second_init: got %h want %h", obs, exp_v);
        end
        wait_cycles(1);
        exp_v = {1'b1, 1'b1, 2'd1, 8'd0, 1'b1};
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL timeout_period40: got %h want %h", obs, exp_v);
        end
        wait_cycles(8);
        exp_v = {1'b0, 1'b1, 2'd2, 8'd0, 1'b1};
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL timeout_sticky: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_async_reset();
        #2;
        reset = 1'b1;
        #1;
        exp_v = {1'b1, 1'b1, 2'd0, 8'd0, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL async_reset_init: got %h want %h", obs, exp_v);
        end
        @(negedge clock);
        pll_locked = 1'b0;
        sdram_init_done = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b1;
            wait_cycles(3);
            pll_locked = 1'b0;
            wait_cycles(3);
            if (i == 9) begin
                exp_v = {1'b1, 1'b1, 2'd0, 8'd10, 1'b0};
                n_cmp++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL sat_count10: got %h want %h", obs, exp_v);
                end
            end
        end
        exp_v = {1'b1, 1'b1, 2'd0, 8'd255, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL sat_255: got %h want %h", obs, exp_v);
        end
        #2;
        reset = 1'b1;
        #1;
        exp_v = {1'b1, 1'b1, 2'd0, 8'd0, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL sat_reset_clear: got %h want %h", obs, exp_v);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_lock_loss_run();
        test_late_done();
        test_glitch_stable();
        test_timeout();
        test_async_reset();
        test_saturation();
        wait_cycles(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
